histogram_readout_controller: RTL and testbench
===============================================

# histogram_readout_controller

Streams the 2-D THGEM histogram out of DDR2 once acquisition is stopped. It reads every bin sequentially through one DDR2 memory controller port and pushes each count into the transfer FIFO that feeds the host link, preceded by a header word. Optionally it zeroes each bin after reading it, which re-arms the histogram. It is the reader and drainer of the memory image that the histogramming controller builds by read-modify-write, and it shares that controller's pX_* port protocol and bin address map.

## Interface
- NUM_BINS_LOG2, 20, log2 of the bin count. 10 bits X plus 10 bits Y. Legal range 2–28.
- HDR_WORD, 32'hFFFFFFFF, first word pushed for each dump.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- clear_en  in  1  latched at start; 1 = zero each bin after reading it
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the dump completes
- pX_ready  in  1  memory controller ready
- pX_data_out  out  32  write data (always 0: clear only)
- pX_data_in  in  32  read data
- pX_data_ready  in  1  read data valid
- pX_addr  out  30  word address
- pX_read_write  out  1  1 = read, 0 = write
- pX_mem_op  out  1  command strobe
- fifo_din  out  32  transfer FIFO write data
- fifo_wr_en  out  1  transfer FIFO write strobe
- fifo_full  in  1  transfer FIFO full flag

## Operation
- Reset values: all outputs 0 except pX_read_write=1. The bin index resets to 0, clr_latched to 0, and the state to IDLE.
- Defaults every cycle: pX_mem_op=0, pX_read_write=1, fifo_wr_en=0, done=0.
- Address: pX_addr = {zero-extend, idx, 2'b00}. idx[9:0] maps to pX_addr[11:2] (X) and idx[19:10] maps to pX_addr[21:12] (Y). Bits above 2+NUM_BINS_LOG2 are 0.
- States:
  - IDLE: start=1 latches clear_en, sets idx=0 and goes to HDR.
  - HDR: if ~fifo_full, drive fifo_din=HDR_WORD with fifo_wr_en=1 and go to RD_REQ. Otherwise stay.
  - RD_REQ: if pX_ready, drive pX_mem_op=1, pX_read_write=1, load cnt=2 and go to RD_HOLD.
  - RD_HOLD: while cnt>0, hold pX_mem_op=1, pX_read_write=1 and decrement cnt. At cnt=0 go to RD_WAIT.
  - RD_WAIT: on pX_data_ready, capture pX_data_in into the data register and go to PUSH.
  - PUSH: if ~fifo_full, drive fifo_din=data with fifo_wr_en=1. Go to CLR_REQ if clr_latched, else NEXT. If full, stay.
  - CLR_REQ: if pX_ready, drive pX_mem_op=1, pX_read_write=0, pX_data_out=0, load cnt=1 and go to CLR_HOLD.
  - CLR_HOLD: while cnt>0, hold pX_mem_op=1, pX_read_write=0 and decrement cnt. At cnt=0 go to CLR_WAIT.
  - CLR_WAIT: on pX_ready, go to NEXT.
  - NEXT: if idx == 2^NUM_BINS_LOG2−1, go to DONE. Otherwise increment idx and go to RD_REQ.
  - DONE: done=1 and go to IDLE.
- Read strobe is 3 cycles; write strobe is 2 cycles. pX_addr is stable for the whole command and until the next idx change.
- start while busy is ignored. clear_en changes mid-dump have no effect.
- idx never wraps; the terminal index ends the dump.
- A 0xFFFFFFFF bin count is pushed verbatim. The host frames dumps by word count, not by value.
- Reset mid-dump: next cycle is IDLE with reset values. No FIFO word and no memory strobe are issued after reset, and a partial dump is not resumed.

## Timing
- start accepted at edge k: busy=1 and state=HDR at k+1. Header is pushed at k+1 if the FIFO is not full.
- Per bin, with pX_ready and FIFO always available and read data returning D cycles after RD_WAIT entry:
  - no clear: 1+2+(D+1)+1+1 cycles
  - with clear: +1+1+1 cycles
- fifo_full stalls only HDR and PUSH. The memory port is idle during a stall.
- done is asserted for exactly 1 cycle; busy drops in the same cycle.

## Structure
- Shared package hist_pkg:
  - state enum
  - RD_STROBE_CYC=3, WR_STROBE_CYC=2
  - HDR_WORD default
  - bin_to_addr function: idx to the 30-bit address. The histogramming controller uses the same map.
- One natural sub-module, mem_port_cmd. It issues the strobed read or write command with its counter, given a req/rw pulse, and returns cmd_done. Both the read and clear paths reuse it.

## Test plan
- NUM_BINS_LOG2=2, memory model holds {5,0,7,0xFFFFFFFF}, clear_en=0, start pulse → FIFO receives FFFFFFFF,5,0,7,FFFFFFFF. done pulses once, busy high throughout, memory unchanged.
- Same image, clear_en=1 → same FIFO stream. All 4 bins read 0 afterwards; exactly 4 write commands, each with a 2-cycle strobe and pX_data_out=0.
- fifo_full held high for 10 cycles during the PUSH of bin 2 → no fifo_wr_en while full, no memory command issued, and the stream stays intact and ordered.
- pX_ready low for 5 cycles at RD_REQ, pX_data_ready delayed 7 cycles → pX_mem_op is high for exactly 3 cycles after ready, and pX_addr is stable throughout.
- NUM_BINS_LOG2=20, idx=1025 → pX_addr=30'h0001004 (X=1, Y=1). Terminal idx 0xFFFFF → DONE with no wrap.
- reset asserted in RD_HOLD → next cycle all outputs are at reset values. A new start produces a full dump beginning with HDR_WORD and bin 0.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram controllers: FSM states, command strobe
// lengths, the header word and the bin-index to DDR2 word-address map.
package hist_pkg;

  localparam int unsigned RD_STROBE_CYC = 3;
  localparam int unsigned WR_STROBE_CYC = 2;
  localparam int unsigned CNT_W         = 2;
  localparam int unsigned ADDR_W        = 30;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned IDX_MAX_W     = 28;

  localparam logic [DATA_W-1:0] HDR_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    RD_REQ,
    RD_HOLD,
    RD_WAIT,
    PUSH,
    CLR_REQ,
    CLR_HOLD,
    CLR_WAIT,
    NEXT,
    DONE
  } state_t;

  // idx[9:0] is X -> addr[11:2], idx[19:10] is Y -> addr[21:12]; upper bits stay zero
  function automatic logic [ADDR_W-1:0] bin_to_addr(input logic [IDX_MAX_W-1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_cmd.sv
// Issues one strobed DDR2 port command (3-cycle read or 2-cycle write) from a
// single-cycle req pulse and flags cmd_done on the last strobe cycle.
module mem_port_cmd
  import hist_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic rw,
  output logic mem_op,
  output logic read_write,
  output logic cmd_done
);

  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             rw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_op     <= 1'b0;
      read_write <= 1'b1;
      active     <= 1'b0;
      rw_q       <= 1'b1;
      cnt        <= '0;
    end else begin
      mem_op     <= 1'b0;
      read_write <= 1'b1;
      if (req) begin
        mem_op     <= 1'b1;
        read_write <= rw;
        rw_q       <= rw;
        active     <= 1'b1;
        cnt        <= rw ? CNT_W'(RD_STROBE_CYC - 1) : CNT_W'(WR_STROBE_CYC - 1);
      end else if (active) begin
        if (cnt != '0) begin
          mem_op     <= 1'b1;
          read_write <= rw_q;
          cnt        <= cnt - CNT_W'(1);
        end else begin
          active <= 1'b0;
        end
      end
    end
  end

  assign cmd_done = active && (cnt == '0);

endmodule

// File: rtl/histogram_readout_controller.sv
// Dumps the DDR2 histogram image into the host transfer FIFO: a header word,
// then every bin in index order, optionally zeroing each bin after it is read.
module histogram_readout_controller
  import hist_pkg::*;
#(
  parameter int unsigned       NUM_BINS_LOG2 = 20,
  parameter logic [DATA_W-1:0] HDR_WORD      = HDR_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_en,
  output logic              busy,
  output logic              done,
  input  logic              pX_ready,
  output logic [DATA_W-1:0] pX_data_out,
  input  logic [DATA_W-1:0] pX_data_in,
  input  logic              pX_data_ready,
  output logic [ADDR_W-1:0] pX_addr,
  output logic              pX_read_write,
  output logic              pX_mem_op,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full
);

  state_t                   state;
  logic [NUM_BINS_LOG2-1:0] idx;
  logic                     clr_latched;
  logic [DATA_W-1:0]        data;
  logic                     cmd_req;
  logic                     cmd_rw;
  logic                     cmd_done;

  // Command is launched on the same edge the request state sees pX_ready
  assign cmd_req     = pX_ready && ((state == RD_REQ) || (state == CLR_REQ));
  assign cmd_rw      = (state == RD_REQ);
  assign pX_addr     = bin_to_addr(IDX_MAX_W'(idx));
  assign pX_data_out = '0;

  mem_port_cmd u_mem_port_cmd (
    .clk        (clk),
    .reset      (reset),
    .req        (cmd_req),
    .rw         (cmd_rw),
    .mem_op     (pX_mem_op),
    .read_write (pX_read_write),
    .cmd_done   (cmd_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      clr_latched <= 1'b0;
      data        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fifo_din    <= '0;
      fifo_wr_en  <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            clr_latched <= clear_en;
            idx         <= '0;
            busy        <= 1'b1;
            state       <= HDR;
          end
        end
        HDR: begin
          if (!fifo_full) begin
            fifo_din   <= HDR_WORD;
            fifo_wr_en <= 1'b1;
            state      <= RD_REQ;
          end
        end
        RD_REQ:   if (pX_ready) state <= RD_HOLD;
        RD_HOLD:  if (cmd_done) state <= RD_WAIT;
        RD_WAIT: begin
          if (pX_data_ready) begin
            data  <= pX_data_in;
            state <= PUSH;
          end
        end
        PUSH: begin
          if (!fifo_full) begin
            fifo_din   <= data;
            fifo_wr_en <= 1'b1;
            state      <= clr_latched ? CLR_REQ : NEXT;
          end
        end
        CLR_REQ:  if (pX_ready) state <= CLR_HOLD;
        CLR_HOLD: if (cmd_done) state <= CLR_WAIT;
        CLR_WAIT: if (pX_ready) state <= NEXT;
        NEXT: begin
          if (idx == '1) begin
            state <= DONE;
          end else begin
            idx   <= idx + NUM_BINS_LOG2'(1);
            state <= RD_REQ;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_readout_controller.sv
// Directed bench for histogram_readout_controller with a 4-bin image, a DDR2
// port model and a transfer-FIFO model driven and sampled on the falling edge.
module tb_histogram_readout_controller;
  import hist_pkg::*;

  localparam int unsigned NB_LOG2 = 2;
  localparam int unsigned NB      = 4;
  localparam logic [31:0] HDR     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        clear_en = 1'b0;
  logic        busy;
  logic        done;
  logic        pX_ready = 1'b1;
  logic [31:0] pX_data_out;
  logic [31:0] pX_data_in = '0;
  logic        pX_data_ready = 1'b0;
  logic [29:0] pX_addr;
  logic        pX_read_write;
  logic        pX_mem_op;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;

  always #5 clk = ~clk;

  histogram_readout_controller #(.NUM_BINS_LOG2(NB_LOG2), .HDR_WORD(HDR)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .clear_en      (clear_en),
    .busy          (busy),
    .done          (done),
    .pX_ready      (pX_ready),
    .pX_data_out   (pX_data_out),
    .pX_data_in    (pX_data_in),
    .pX_data_ready (pX_data_ready),
    .pX_addr       (pX_addr),
    .pX_read_write (pX_read_write),
    .pX_mem_op     (pX_mem_op),
    .fifo_din      (fifo_din),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [NB];
  logic [31:0] img [NB];
  logic [31:0] fifo_q [$];
  logic [29:0] rd_addr_q [$];
  int rd_cmds, wr_cmds, strobe_bad, addr_bad, wdata_bad;
  int wr_while_full, cmd_while_full, cmd_while_not_ready, done_cnt, busy_bad;
  int rd_delay = 0;
  int ready_low = 0;
  int full_cycles = 0;
  bit dumping = 1'b0;
  bit arm_full = 1'b0;
  bit arm_ready = 1'b0;
  bit full_hit = 1'b0;
  bit ready_hit = 1'b0;

  // DDR2 port + FIFO model: records commands, returns read data, applies stalls
  initial begin : port_model
    logic        prev_op, prev_ready, prev_full, cmd_rw, rd_armed;
    logic [29:0] cmd_addr;
    logic [31:0] rd_data;
    int          strobe, rd_timer;
    prev_op = 1'b0; rd_armed = 1'b0; cmd_rw = 1'b1; cmd_addr = '0;
    rd_data = '0; strobe = 0; rd_timer = 0;
    forever begin
      @(negedge clk);
      prev_ready    = pX_ready;
      prev_full     = fifo_full;
      pX_data_ready = 1'b0;
      if (reset) begin
        prev_op  = 1'b0;
        rd_armed = 1'b0;
      end else begin
        if (fifo_wr_en) begin
          fifo_q.push_back(fifo_din);
          if (prev_full) wr_while_full++;
          if (arm_ready && fifo_q.size() == 1) begin
            ready_low = 5; arm_ready = 1'b0; ready_hit = 1'b1;
          end
        end
        if (pX_mem_op && !prev_op) begin
          cmd_addr = pX_addr; cmd_rw = pX_read_write; strobe = 1;
          if (!prev_ready) cmd_while_not_ready++;
          if (prev_full) cmd_while_full++;
          if (cmd_rw) begin
            rd_cmds++;
            rd_addr_q.push_back(cmd_addr);
            if (arm_full && cmd_addr == 30'h8) begin
              full_cycles = 10; arm_full = 1'b0; full_hit = 1'b1;
            end
          end else begin
            wr_cmds++;
            if (pX_data_out !== 32'd0) wdata_bad++;
            mem[cmd_addr[3:2]] = pX_data_out;
          end
        end else if (pX_mem_op) begin
          strobe++;
          if (pX_addr !== cmd_addr || pX_read_write !== cmd_rw) addr_bad++;
        end else if (prev_op) begin
          if (strobe != (cmd_rw ? 3 : 2)) strobe_bad++;
          if (cmd_rw) begin
            rd_armed = 1'b1; rd_timer = rd_delay; rd_data = mem[cmd_addr[3:2]];
          end
        end
        prev_op = pX_mem_op;
        if (rd_armed) begin
          if (rd_timer == 0) begin
            pX_data_ready = 1'b1; pX_data_in = rd_data; rd_armed = 1'b0;
          end else begin
            rd_timer--;
          end
        end
        if (done) begin
          done_cnt++;
          if (busy) busy_bad++;
        end else if (dumping && !busy) begin
          busy_bad++;
        end
      end
      if (ready_low > 0) begin pX_ready = 1'b0; ready_low--; end
      else pX_ready = 1'b1;
      if (full_cycles > 0) begin fifo_full = 1'b1; full_cycles--; end
      else fifo_full = 1'b0;
    end
  end

  task automatic load_image();
    for (int i = 0; i < NB; i++) mem[i] = img[i];
  endtask

  task automatic clear_stats();
    fifo_q.delete(); rd_addr_q.delete();
    rd_cmds = 0; wr_cmds = 0; strobe_bad = 0; addr_bad = 0; wdata_bad = 0;
    wr_while_full = 0; cmd_while_full = 0; cmd_while_not_ready = 0;
    done_cnt = 0; busy_bad = 0; full_hit = 1'b0; ready_hit = 1'b0;
  endtask

  // Pulse start, flip clear_en afterwards (must be ignored), wait for done
  task automatic run_dump(input string tag, input bit clr, input int mid_start);
    bit seen;
    seen = 1'b0;
    start = 1'b1; clear_en = clr;
    @(negedge clk);
    start = 1'b0; clear_en = ~clr; dumping = 1'b1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      start = (c == mid_start);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0; dumping = 1'b0; clear_en = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_busy_bad"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_fifo_words"}, 64'(fifo_q.size()), 64'(NB + 1));
    for (int i = 0; i < NB + 1 && i < fifo_q.size(); i++)
      check_eq($sformatf("%s_word%0d", tag, i), 64'(fifo_q[i]),
               64'((i == 0) ? HDR : img[i-1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_mem_op"}, 64'(pX_mem_op), 64'd0);
    check_eq({tag, "_read_write"}, 64'(pX_read_write), 64'd1);
    check_eq({tag, "_fifo_wr_en"}, 64'(fifo_wr_en), 64'd0);
    check_eq({tag, "_fifo_din"}, 64'(fifo_din), 64'd0);
    check_eq({tag, "_addr"}, 64'(pX_addr), 64'd0);
    check_eq({tag, "_data_out"}, 64'(pX_data_out), 64'd0);
  endtask

  initial begin : main
    bit hit;
    img[0] = 32'd5; img[1] = 32'd0; img[2] = 32'd7; img[3] = 32'hFFFF_FFFF;
    load_image();
    clear_stats();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Address map at full size: X=1,Y=1 and terminal index
    check_eq("addr_1025", 64'(bin_to_addr(28'd1025)), 64'h0001004);
    check_eq("addr_term", 64'(bin_to_addr(28'hFFFFF)), 64'h03FFFFC);
    reset = 1'b0;
    @(negedge clk);

    // Plain dump, no clear
    load_image(); clear_stats();
    run_dump("t1", 1'b0, -1);
    check_stream("t1");
    check_eq("t1_rd_cmds", 64'(rd_cmds), 64'd4);
    check_eq("t1_wr_cmds", 64'(wr_cmds), 64'd0);
    check_eq("t1_strobe_bad", 64'(strobe_bad), 64'd0);
    for (int i = 0; i < NB && i < rd_addr_q.size(); i++)
      check_eq($sformatf("t1_rd_addr%0d", i), 64'(rd_addr_q[i]), 64'(i * 4));
    for (int i = 0; i < NB; i++)
      check_eq($sformatf("t1_mem%0d", i), 64'(mem[i]), 64'(img[i]));

    // Dump with clear, plus a start pulse mid-dump that must be ignored
    load_image(); clear_stats();
    run_dump("t2", 1'b1, 20);
    check_stream("t2");
    check_eq("t2_rd_cmds", 64'(rd_cmds), 64'd4);
    check_eq("t2_wr_cmds", 64'(wr_cmds), 64'd4);
    check_eq("t2_strobe_bad", 64'(strobe_bad), 64'd0);
    check_eq("t2_wdata_bad", 64'(wdata_bad), 64'd0);
    for (int i = 0; i < NB; i++)
      check_eq($sformatf("t2_mem%0d", i), 64'(mem[i]), 64'd0);

    // FIFO full for 10 cycles around the push of bin 2
    load_image(); clear_stats(); arm_full = 1'b1;
    run_dump("t3", 1'b0, -1);
    check_stream("t3");
    check_eq("t3_full_hit", 64'(full_hit), 64'd1);
    check_eq("t3_wr_while_full", 64'(wr_while_full), 64'd0);
    check_eq("t3_cmd_while_full", 64'(cmd_while_full), 64'd0);

    // pX_ready low 5 cycles at first RD_REQ, read data 7 cycles late
    load_image(); clear_stats(); arm_ready = 1'b1; rd_delay = 7;
    run_dump("t4", 1'b0, -1);
    rd_delay = 0;
    check_stream("t4");
    check_eq("t4_ready_hit", 64'(ready_hit), 64'd1);
    check_eq("t4_cmd_not_ready", 64'(cmd_while_not_ready), 64'd0);
    check_eq("t4_strobe_bad", 64'(strobe_bad), 64'd0);
    check_eq("t4_addr_bad", 64'(addr_bad), 64'd0);

    // Reset while the first read strobe is held, then a fresh full dump
    load_image(); clear_stats();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (pX_mem_op) hit = 1'b1;
      else @(negedge clk);
    end
    check_eq("t5_strobe_seen", 64'(hit), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_idle_no_fifo", 64'(fifo_wr_en), 64'd0);
    clear_stats();
    run_dump("t5", 1'b0, -1);
    check_stream("t5");
    check_eq("t5_rd_cmds", 64'(rd_cmds), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
